// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key conditioner: channel state type and
// the per-channel counter width helper.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DEB,
    HELD,
    REPEAT,
    REL_DEB
  } ch_state_t;

  // Width able to hold 0..max(a,b,c)-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Pin-side and event-side signals of the key conditioner.
interface key_debounce_if #(
  parameter int unsigned N_KEYS = 4
);

  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] repeat_pulse;

  modport master (
    output key_raw,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse
  );

  modport slave (
    input  key_raw,
    output key_level,
    output press_pulse,
    output release_pulse,
    output repeat_pulse
  );

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce/auto-repeat FSM and
// registered level/pulse outputs, advanced by the shared tick.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned DEB_TICKS    = 20,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic rst_N,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CW = cnt_width(DEB_TICKS, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_TICKS - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
  localparam logic          INACTIVE   = (ACTIVE_LOW != 0);

  logic      sync1, sync2;
  logic      k;
  ch_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic      press_nx, release_nx, repeat_nx, level_nx;

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      sync1 <= INACTIVE;
      sync2 <= INACTIVE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign k = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state         <= IDLE;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      level         <= level_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      repeat_pulse  <= repeat_nx;
    end
  end

  // A level change on k always wins over a coincident tick.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    repeat_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (k) begin
          state_nx = PRESS_DEB;
          cnt_nx   = '0;
        end
      end
      PRESS_DEB: begin
        if (!k) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (tick) begin
          if (cnt == DEB_LAST) begin
            state_nx = HELD;
            cnt_nx   = '0;
            press_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      HELD: begin
        if (!k) begin
          state_nx = REL_DEB;
          cnt_nx   = '0;
        end else if (tick) begin
          if (cnt == DELAY_LAST) begin
            state_nx  = REPEAT;
            cnt_nx    = '0;
            repeat_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!k) begin
          state_nx = REL_DEB;
          cnt_nx   = '0;
        end else if (tick) begin
          if (cnt == RATE_LAST) begin
            cnt_nx    = '0;
            repeat_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      REL_DEB: begin
        if (k) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (tick) begin
          if (cnt == DEB_LAST) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            release_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    level_nx = (state_nx == HELD) || (state_nx == REPEAT) || (state_nx == REL_DEB);
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: shared 1 ms-style tick prescaler feeding
// N_KEYS independent debounce/auto-repeat channels.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS       = 4,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned DEB_TICKS    = 20,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic     clk,
  input  logic     rst_N,
  key_debounce_if.slave keys
);

  localparam int unsigned TW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  if (TICK_DIV < 1 || DEB_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("key_debounce: tick and count parameters must all be >= 1");
  end

  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [N_KEYS-1:0] level, press, rel, rep;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DEB_TICKS    (DEB_TICKS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk           (clk),
      .rst_N         (rst_N),
      .tick          (tick),
      .raw           (keys.key_raw[i]),
      .level         (level[i]),
      .press_pulse   (press[i]),
      .release_pulse (rel[i]),
      .repeat_pulse  (rep[i])
    );
  end

  assign keys.key_level     = level;
  assign keys.press_pulse   = press;
  assign keys.release_pulse = rel;
  assign keys.repeat_pulse  = rep;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: run-length reference model compared every cycle,
// directed scenarios with literal latencies/counts, then random key activity.
module tb_key_debounce;

  localparam int NK  = 4;
  localparam int TD  = 4;
  localparam int DEB = 3;
  localparam int RD  = 10;
  localparam int RR  = 4;

  logic clk = 1'b0;
  logic rst_N;
  always #5 clk = ~clk;

  key_debounce_if #(.N_KEYS(NK)) kif ();

  key_debounce #(
    .N_KEYS       (NK),
    .ACTIVE_LOW   (1),
    .TICK_DIV     (TD),
    .DEB_TICKS    (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk   (clk),
    .rst_N (rst_N),
    .keys  (kif)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: pressed/released is decided by how many ticks a
  // synchronised level has persisted; repeats by ticks since the hold began.
  bit h1[NK], h2[NK], run_val[NK], mlev[NK];
  int run_ticks[NK], anchor[NK];
  int edge_idx = 0;
  bit m_tk, m_k;
  logic [NK-1:0] exp_lvl = '0, exp_prs = '0, exp_rel = '0, exp_rep = '0;

  always @(posedge clk) begin
    exp_prs = '0;
    exp_rel = '0;
    exp_rep = '0;
    if (!rst_N) begin
      edge_idx = 0;
      for (int i = 0; i < NK; i++) begin
        h1[i] = 1'b1; h2[i] = 1'b1;
        run_val[i] = 1'b0; mlev[i] = 1'b0;
        run_ticks[i] = 0; anchor[i] = 0;
      end
      exp_lvl = '0;
    end else begin
      m_tk = ((edge_idx % TD) == TD - 1);
      edge_idx++;
      for (int i = 0; i < NK; i++) begin
        m_k = ~h2[i];
        h2[i] = h1[i];
        h1[i] = kif.key_raw[i];
        if (m_k != run_val[i]) begin
          run_val[i] = m_k;
          run_ticks[i] = 0;
          if (mlev[i] && m_k) anchor[i] = 0;
        end else if (m_tk) begin
          run_ticks[i]++;
          if (!mlev[i] && m_k && run_ticks[i] == DEB) begin
            exp_prs[i] = 1'b1; mlev[i] = 1'b1; anchor[i] = 0;
          end else if (mlev[i] && !m_k && run_ticks[i] == DEB) begin
            exp_rel[i] = 1'b1; mlev[i] = 1'b0;
          end else if (mlev[i] && m_k) begin
            anchor[i]++;
            if (anchor[i] == RD || (anchor[i] > RD && (anchor[i] - RD) % RR == 0))
              exp_rep[i] = 1'b1;
          end
        end
        exp_lvl[i] = mlev[i];
      end
    end
  end

  always @(negedge clk) begin
    check("key_level", 32'(kif.key_level), 32'(exp_lvl));
    check("press_pulse", 32'(kif.press_pulse), 32'(exp_prs));
    check("release_pulse", 32'(kif.release_pulse), 32'(exp_rel));
    check("repeat_pulse", 32'(kif.repeat_pulse), 32'(exp_rep));
  end

  int w_prs[NK], w_rel[NK], w_rep[NK], w_mrep[NK];

  task automatic clear_win();
    for (int i = 0; i < NK; i++) begin
      w_prs[i] = 0; w_rel[i] = 0; w_rep[i] = 0; w_mrep[i] = 0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < NK; i++) begin
      w_prs[i]  += int'(kif.press_pulse[i]);
      w_rel[i]  += int'(kif.release_pulse[i]);
      w_rep[i]  += int'(kif.repeat_pulse[i]);
      w_mrep[i] += int'(exp_rep[i]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) cyc();
  endtask

  // kind: 0 press, 1 release, 2 repeat; n = cycles waited, -1 on timeout
  task automatic wait_pulse(input int key, input int kind, input int maxc, output int n);
    logic [NK-1:0] v;
    n = -1;
    for (int c = 1; c <= maxc; c++) begin
      cyc();
      case (kind)
        0:       v = kif.press_pulse;
        1:       v = kif.release_pulse;
        default: v = kif.repeat_pulse;
      endcase
      if (v[key]) begin
        n = c;
        break;
      end
    end
  endtask

  int n;
  int dur[NK];

  initial begin
    rst_N = 1'b0;
    kif.key_raw = '1;
    clear_win();
    repeat (3) @(negedge clk);
    check("reset_level", 32'(kif.key_level), 32'h0);
    check("reset_press", 32'(kif.press_pulse), 32'h0);
    rst_N = 1'b1;
    step(10);

    // clean press on key 0, then auto-repeat window, then release
    kif.key_raw[0] = 1'b0;
    wait_pulse(0, 0, 30, n);
    check_range("t1_press_latency", n, 12, 15);
    check("t1_level_after_press", 32'(kif.key_level[0]), 32'h1);
    clear_win();
    step(RD * TD + 5 * RR * TD);
    check("t3_repeat_count", 32'(w_rep[0]), 32'd6);
    check("t3_model_repeat_count", 32'(w_mrep[0]), 32'd6);
    check("t3_no_dup_press", 32'(w_prs[0]), 32'd0);
    kif.key_raw[0] = 1'b1;
    wait_pulse(0, 1, 30, n);
    check_range("t1_release_latency", n, 12, 15);
    check("t1_level_after_release", 32'(kif.key_level[0]), 32'h0);
    step(10);

    // bounce on key 1
    clear_win();
    kif.key_raw[1] = 1'b0; step(2 * TD);
    kif.key_raw[1] = 1'b1; step(TD);
    kif.key_raw[1] = 1'b0; step(TD);
    kif.key_raw[1] = 1'b1; step(40);
    check("t2_no_press", 32'(w_prs[1]), 32'd0);
    check("t2_no_release", 32'(w_rel[1]), 32'd0);
    check("t2_level", 32'(kif.key_level[1]), 32'h0);

    // release glitch while held restarts the repeat delay
    kif.key_raw[0] = 1'b0;
    wait_pulse(0, 0, 30, n);
    check_range("t4_press_latency", n, 12, 15);
    step(20);
    clear_win();
    kif.key_raw[0] = 1'b1; step(2 * TD);
    kif.key_raw[0] = 1'b0;
    wait_pulse(0, 2, 60, n);
    check_range("t4_repeat_after_glitch", n, 40, 43);
    check("t4_no_release", 32'(w_rel[0]), 32'd0);
    check("t4_level_held", 32'(kif.key_level[0]), 32'h1);

    // async reset while in REPEAT, key still held through reset release
    step(3);
    #1 rst_N = 1'b0;
    #1;
    check("t5_rst_level", 32'(kif.key_level), 32'h0);
    check("t5_rst_press", 32'(kif.press_pulse), 32'h0);
    check("t5_rst_release", 32'(kif.release_pulse), 32'h0);
    check("t5_rst_repeat", 32'(kif.repeat_pulse), 32'h0);
    step(3);
    rst_N = 1'b1;
    wait_pulse(0, 0, 30, n);
    check("t5_press_after_reset", 32'(n), 32'd12);
    kif.key_raw[0] = 1'b1;
    wait_pulse(0, 1, 30, n);
    check_range("t5_release_latency", n, 12, 15);
    step(10);

    // simultaneous press on keys 0 and 3
    kif.key_raw[0] = 1'b0;
    kif.key_raw[3] = 1'b0;
    n = -1;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      if (kif.press_pulse != '0) begin
        n = c;
        break;
      end
    end
    check_range("t6_press_seen", n, 12, 15);
    check("t6_press_vec", 32'(kif.press_pulse), 32'h9);
    kif.key_raw = '1;
    step(40);

    // random key activity, mixing bounces and long holds
    for (int i = 0; i < NK; i++) dur[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      cyc();
      for (int i = 0; i < NK; i++) begin
        if (dur[i] == 0) begin
          kif.key_raw[i] = 1'($urandom_range(0, 1));
          dur[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12))
                                               : int'($urandom_range(13, 160));
        end else begin
          dur[i]--;
        end
      end
    end
    kif.key_raw = '1;
    step(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
